dcache_dm: RTL and testbench
============================

DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 The module SHALL have these ports (name direction width meaning), clock and reset first:
- CLK in 1: single clock; all state changes on the rising edge.
- nRST in 1: reset, asynchronous, active-low.
- halt in 1: datapath halted; starts the flush.
- dmemREN in 1: datapath load request.
- dmemWEN in 1: datapath store request.
- datomic in 1: the request is LL (with REN) or SC (with WEN).
- dmemaddr in 32: word address; tag [31:6], index [5:3], block offset [2], [1:0] ignored.
- dmemstore in 32: store data.
- dhit out 1: request complete this cycle.
- dmemload out 32: load data, or SC result.
- dREN out 1: memory read request.
- dWEN out 1: memory write request.
- daddr out 32: memory word address.
- dstore out 32: memory write data.
- dwait in 1: memory busy; a memory access completes in the first cycle that dWEN or dREN is high with dwait low.
- dload in 32: memory read data.
- flushed out 1: flush complete.

Function
REQ-002 The cache SHALL be direct-mapped: 8 frames, each holding valid, dirty, 26-bit tag and 2 words; policy is write-back, write-allocate.
REQ-003 In IDLE, a request SHALL hit when the indexed frame is valid and its tag matches; dhit SHALL assert combinationally in that same cycle.
REQ-004 On a load hit, dmemload SHALL equal the selected word in the same cycle.
REQ-005 On a store hit, the word SHALL be written and dirty set at the next edge.
REQ-006 If dmemWEN and dmemREN are both high, the request SHALL be handled as a store.
REQ-007 On a miss, the FSM SHALL go to WB0 if the frame is dirty, else to LD0.
REQ-008 Write-back SHALL use two states: WB0 writes word0 and WB1 writes word1 to {old tag, index, offset, 00}; each state holds until dwait is low.
REQ-009 Refill SHALL use LD0 then LD1, each holding until dwait is low; after LD1 the frame gets the new tag, valid=1, dirty=0, and the FSM returns to IDLE, where the retried request hits.
REQ-010 dhit SHALL be low in every state except IDLE.
REQ-011 dREN and dWEN SHALL be low in IDLE and never high together.
REQ-012 Miss penalty with dwait always low SHALL be 2 cycles (clean frame) or 4 cycles (dirty frame), plus the hit cycle.
REQ-013 Flush: on the first cycle halt is high in IDLE, the FSM SHALL enter FLUSH and walk index 0..7 with a 3-bit counter.
REQ-014 During FLUSH, each dirty frame SHALL be written back through FWB0/FWB1 and then have dirty cleared; clean frames SHALL take one cycle each.
REQ-015 After index 7 the FSM SHALL enter DONE and hold flushed=1 until reset.
REQ-016 A halt that arrives mid-miss SHALL be deferred until the FSM returns to IDLE.
REQ-017 In FLUSH and DONE, requests SHALL be ignored and dhit SHALL stay 0.
REQ-018 Counter wrap 7->0 SHALL never occur; DONE is terminal.

Reset
REQ-019 On nRST low, immediately: all valid/dirty/tag/data cleared, FSM=IDLE, flush counter=0, link register invalid.
REQ-020 Output values during reset: dhit=0, dREN=0, dWEN=0, daddr=0, dstore=0, dmemload=0, flushed=0.
REQ-021 A reset in any state, including mid-miss or mid-flush, SHALL discard all partial progress.

Configuration
REQ-022 When DCACHE_LLSC_EN is defined, the design SHALL include a 32-bit link register with a valid bit, with this behaviour:
- LL hit: load the word and set link := dmemaddr, valid=1.
- SC hit with the link valid and the address equal: perform the store, return dmemload=1, clear the link.
- Any other SC hit: no store, return dmemload=0.
- Any successful store hit to the linked address: clear the link.
REQ-023 When DCACHE_LLSC_EN is not defined, datomic SHALL be ignored: LL behaves as a plain load, and SC behaves as a plain store with dmemload=1.

Verification
REQ-024 Cold load 0x40, dwait=0, mem[0x40]=0xDEAD -> dREN for 2 cycles at daddrs 0x40, 0x44, then dhit with dmemload=0xDEAD.
REQ-025 Store 0x1234 to 0x40 (hit), then load 0x240 (same index, different tag) -> dWEN at 0x40 (dstore=0x1234), then 0x44, then dREN at 0x240, 0x244, then dhit; total 5 cycles.
REQ-026 dwait held high 3 cycles during LD0 -> dREN and daddr stable, dhit=0 throughout, and completion on the first cycle dwait is low.
REQ-027 Dirty frames at indices 2 and 5, then halt -> exactly 4 dWEN writes at index 2 then index 5 block addresses; flushed=1 after index 7 and held.
REQ-028 With DCACHE_LLSC_EN: LL 0x80; SW 0x80; SC 0x80 -> SC returns dmemload=0 and memory is unchanged. Sequence LL 0x80; SC 0x80 -> returns 1 and the word is updated.
REQ-029 nRST pulsed during WB1 -> all outputs 0 immediately; a subsequent load to the same address misses with no write-back.

Source files
------------

// File: rtl/dcache_dm_if.sv
// Datapath-side and memory-side signals of the direct-mapped data cache.
// The cache connects through the slave modport; its environment uses master.
interface dcache_dm_if;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic        datomic;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        flushed;

  modport slave (
    input  halt, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, dwait, dload,
    output dhit, dmemload, dREN, dWEN, daddr, dstore, flushed
  );

  modport master (
    output halt, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, dwait, dload,
    input  dhit, dmemload, dREN, dWEN, daddr, dstore, flushed
  );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped write-back, write-allocate data cache: 8 frames of 2 words, with halt flush.
// Optional LL/SC link register is enabled by defining DCACHE_LLSC_EN.
module dcache_dm (
  input  logic       CLK,
  input  logic       nRST,
  dcache_dm_if.slave bus
);
  typedef enum logic [3:0] {IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE} state_t;

  state_t      state, next_state;
  logic [7:0]  valid, dirty;
  logic [25:0] tags   [8];
  logic [31:0] words0 [8];
  logic [31:0] words1 [8];
  logic [2:0]  cnt;

  logic [25:0] req_tag;
  logic [2:0]  req_idx;
  logic        req_off;
  logic        req, is_store, hit, do_write;
  logic [31:0] atomic_result;
  logic        unused_bits;

  assign req_tag     = bus.dmemaddr[31:6];
  assign req_idx     = bus.dmemaddr[5:3];
  assign req_off     = bus.dmemaddr[2];
  assign req         = bus.dmemREN | bus.dmemWEN;
  assign is_store    = bus.dmemWEN;
  assign hit         = (state == IDLE) && req && valid[req_idx] && (tags[req_idx] == req_tag);
  assign unused_bits = ^{bus.dmemaddr[1:0], bus.datomic};

`ifdef DCACHE_LLSC_EN
  logic [31:0] link;
  logic        link_valid;
  logic        sc_ok;

  assign sc_ok         = link_valid && (link == bus.dmemaddr);
  assign do_write      = hit && is_store && (!bus.datomic || sc_ok);
  assign atomic_result = {31'b0, sc_ok};

  // Any store that lands on the linked word breaks the reservation, SC included.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link       <= '0;
      link_valid <= 1'b0;
    end else if (hit && !is_store && bus.datomic) begin
      link       <= bus.dmemaddr;
      link_valid <= 1'b1;
    end else if (do_write && (bus.dmemaddr == link)) begin
      link_valid <= 1'b0;
    end
  end
`else
  assign do_write      = hit && is_store;
  assign atomic_result = 32'd1;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.halt)        next_state = FLUSH;
        else if (req && !hit) next_state = dirty[req_idx] ? WB0 : LD0;
      end
      WB0:  if (!bus.dwait) next_state = WB1;
      WB1:  if (!bus.dwait) next_state = LD0;
      LD0:  if (!bus.dwait) next_state = LD1;
      LD1:  if (!bus.dwait) next_state = IDLE;
      FLUSH: begin
        if (dirty[cnt])        next_state = FWB0;
        else if (cnt == 3'd7)  next_state = DONE;
      end
      FWB0: if (!bus.dwait) next_state = FWB1;
      FWB1: if (!bus.dwait) next_state = (cnt == 3'd7) ? DONE : FLUSH;
      DONE: next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.dhit     = hit;
    bus.dmemload = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.flushed  = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          if (is_store) bus.dmemload = bus.datomic ? atomic_result : '0;
          else          bus.dmemload = req_off ? words1[req_idx] : words0[req_idx];
        end
      end
      WB0: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tags[req_idx], req_idx, 1'b0, 2'b00};
        bus.dstore = words0[req_idx];
      end
      WB1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tags[req_idx], req_idx, 1'b1, 2'b00};
        bus.dstore = words1[req_idx];
      end
      LD0: begin
        bus.dREN  = 1'b1;
        bus.daddr = {req_tag, req_idx, 1'b0, 2'b00};
      end
      LD1: begin
        bus.dREN  = 1'b1;
        bus.daddr = {req_tag, req_idx, 1'b1, 2'b00};
      end
      FWB0: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tags[cnt], cnt, 1'b0, 2'b00};
        bus.dstore = words0[cnt];
      end
      FWB1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tags[cnt], cnt, 1'b1, 2'b00};
        bus.dstore = words1[cnt];
      end
      DONE:    bus.flushed = 1'b1;
      default: ;
    endcase
  end

  // The frame keeps its old tag until LD1 completes, so a refill is only
  // visible to lookups once both words are in place.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      dirty <= '0;
      for (int i = 0; i < 8; i++) begin
        tags[i]   <= '0;
        words0[i] <= '0;
        words1[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (do_write) begin
            if (req_off) words1[req_idx] <= bus.dmemstore;
            else         words0[req_idx] <= bus.dmemstore;
            dirty[req_idx] <= 1'b1;
          end
        end
        LD0: if (!bus.dwait) words0[req_idx] <= bus.dload;
        LD1: begin
          if (!bus.dwait) begin
            words1[req_idx] <= bus.dload;
            tags[req_idx]   <= req_tag;
            valid[req_idx]  <= 1'b1;
            dirty[req_idx]  <= 1'b0;
          end
        end
        FWB1:    if (!bus.dwait) dirty[cnt] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Flush index stops at 7; DONE is terminal so the counter never wraps.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if ((state == FLUSH && !dirty[cnt]) || (state == FWB1 && !bus.dwait)) begin
      if (cnt != 3'd7) cnt <= cnt + 3'd1;
    end
  end
endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: directed scenarios plus randomized traffic
// checked against a flat architectural memory and a resident-block model.
module tb_dcache_dm;
  logic CLK;
  logic nRST;
  dcache_dm_if bus ();

  dcache_dm dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic        mem_init;
  logic [31:0] bmem [1024];
  logic [31:0] arch [1024];
  logic [5:0]  mtag [8];
  bit          mvalid [8];
  bit          mdirty [8];
  int          wait_pct;
  logic [31:0] last_load;
  int          n_rd, n_wr, n_cyc, n_busy;
  logic [31:0] tr_addr [$];
  logic [31:0] tr_data [$];

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'h0000DEAD;
    return 32'hA5000000 ^ (i * 32'h00010101);
  endfunction

  // Backing memory: one-cycle completion whenever dwait is low.
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) bmem[i] <= init_word(i);
    end else if (bus.dWEN && !bus.dwait) begin
      bmem[bus.daddr[11:2]] <= bus.dstore;
    end
  end
  assign bus.dload = bmem[bus.daddr[11:2]];

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) arch[i] = bmem[i];
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 0;
      mdirty[i] = 0;
      mtag[i]   = '0;
    end
  endtask

  // Predicts memory traffic from block residency; loads return the latest stored value.
  task automatic model_op(input bit we, input logic [31:0] addr, input logic [31:0] data,
                          output int exp_rd, output int exp_wr, output logic [31:0] exp_load);
    int idx;
    idx    = int'(addr[5:3]);
    exp_rd = 0;
    exp_wr = 0;
    if (!(mvalid[idx] && mtag[idx] == addr[11:6])) begin
      exp_rd      = 2;
      exp_wr      = mdirty[idx] ? 2 : 0;
      mvalid[idx] = 1;
      mtag[idx]   = addr[11:6];
      mdirty[idx] = 0;
    end
    exp_load = arch[addr[11:2]];
    if (we) begin
      arch[addr[11:2]] = data;
      mdirty[idx]      = 1;
    end
  endtask

  task automatic idle_inputs();
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.datomic   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    bus.dwait     = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    bus.halt = 1'b0;
    idle_inputs();
    #2 nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic do_req(input bit we, input bit re, input bit at,
                        input logic [31:0] addr, input logic [31:0] data);
    bit done, both;
    n_rd = 0; n_wr = 0; n_cyc = 0; n_busy = 0; done = 0; both = 0;
    tr_addr.delete();
    tr_data.delete();
    @(negedge CLK);
    bus.dmemWEN = we; bus.dmemREN = re; bus.datomic = at;
    bus.dmemaddr = addr; bus.dmemstore = data;
    while (!done) begin
      bus.dwait = ($urandom_range(0, 99) < wait_pct);
      #1;
      if (bus.dREN && bus.dWEN) both = 1;
      if (bus.dREN || bus.dWEN) n_busy++;
      if (bus.dREN && !bus.dwait) begin n_rd++; tr_addr.push_back(bus.daddr); tr_data.push_back(32'h0); end
      if (bus.dWEN && !bus.dwait) begin n_wr++; tr_addr.push_back(bus.daddr); tr_data.push_back(bus.dstore); end
      if (bus.dhit) begin
        last_load = bus.dmemload;
        done = 1;
      end else begin
        n_cyc++;
        if (n_cyc > 100) begin
          errors++;
          $display("FAIL req_timeout addr=%h: no dhit within 100 cycles", addr);
          done = 1;
        end else begin
          @(negedge CLK);
        end
      end
    end
    checks++;
    if (both !== 1'b0) begin
      errors++;
      $display("FAIL strobes_exclusive addr=%h: dREN and dWEN seen together", addr);
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_reset();
    nRST = 1'b0; mem_init = 1'b1; bus.halt = 1'b0;
    idle_inputs();
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h40;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++; if (bus.dhit !== 1'b0)      begin errors++; $display("FAIL rst_dhit got=%b want=0", bus.dhit); end
    checks++; if (bus.dREN !== 1'b0)      begin errors++; $display("FAIL rst_dREN got=%b want=0", bus.dREN); end
    checks++; if (bus.dWEN !== 1'b0)      begin errors++; $display("FAIL rst_dWEN got=%b want=0", bus.dWEN); end
    checks++; if (bus.daddr !== 32'h0)    begin errors++; $display("FAIL rst_daddr got=%h want=0", bus.daddr); end
    checks++; if (bus.dstore !== 32'h0)   begin errors++; $display("FAIL rst_dstore got=%h want=0", bus.dstore); end
    checks++; if (bus.dmemload !== 32'h0) begin errors++; $display("FAIL rst_dmemload got=%h want=0", bus.dmemload); end
    checks++; if (bus.flushed !== 1'b0)   begin errors++; $display("FAIL rst_flushed got=%b want=0", bus.flushed); end
    @(negedge CLK);
    nRST = 1'b1; mem_init = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  task automatic test_cold_load();
    int er, ew; logic [31:0] el;
    wait_pct = 0;
    model_op(0, 32'h40, 32'h0, er, ew, el);
    do_req(0, 1, 0, 32'h40, 32'h0);
    checks++; if (n_rd !== 2 || n_wr !== 0) begin errors++; $display("FAIL cold_traffic rd=%0d wr=%0d want rd=2 wr=0", n_rd, n_wr); end
    checks++;
    if (tr_addr.size() != 2 || tr_addr[0] !== 32'h40 || tr_addr[1] !== 32'h44) begin
      errors++; $display("FAIL cold_addrs got=%p want 40,44", tr_addr);
    end
    checks++; if (n_busy !== 2 || n_cyc !== 3) begin errors++; $display("FAIL cold_latency busy=%0d wait=%0d want 2,3", n_busy, n_cyc); end
    checks++; if (last_load !== 32'h0000DEAD || last_load !== el) begin errors++; $display("FAIL cold_data got=%h want=0000dead", last_load); end
  endtask

  task automatic test_dirty_miss();
    int er, ew; logic [31:0] el;
    model_op(1, 32'h40, 32'h1234, er, ew, el);
    do_req(1, 0, 0, 32'h40, 32'h1234);
    checks++; if (n_cyc !== 0) begin errors++; $display("FAIL store_hit_latency got=%0d want=0", n_cyc); end
    model_op(0, 32'h240, 32'h0, er, ew, el);
    do_req(0, 1, 0, 32'h240, 32'h0);
    checks++; if (n_wr !== 2 || n_rd !== 2) begin errors++; $display("FAIL dirty_traffic wr=%0d rd=%0d want 2,2", n_wr, n_rd); end
    checks++;
    if (tr_addr.size() != 4 || tr_addr[0] !== 32'h40 || tr_addr[1] !== 32'h44 ||
        tr_addr[2] !== 32'h240 || tr_addr[3] !== 32'h244) begin
      errors++; $display("FAIL dirty_addrs got=%p want 40,44,240,244", tr_addr);
    end
    checks++; if (tr_data.size() < 1 || tr_data[0] !== 32'h1234) begin errors++; $display("FAIL dirty_wbdata got=%p want 1234 first", tr_data); end
    checks++; if (n_busy !== 4 || n_cyc !== 5) begin errors++; $display("FAIL dirty_latency busy=%0d wait=%0d want 4,5", n_busy, n_cyc); end
    checks++; if (last_load !== el) begin errors++; $display("FAIL dirty_data got=%h want=%h", last_load, el); end
  endtask

  task automatic test_dwait_stall();
    int er, ew; logic [31:0] el;
    model_op(0, 32'h148, 32'h0, er, ew, el);
    @(negedge CLK);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h148; bus.dwait = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      bus.dwait = 1'b1;
      #1;
      checks++;
      if (bus.dREN !== 1'b1 || bus.daddr !== 32'h148 || bus.dhit !== 1'b0 || bus.dWEN !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d dREN=%b daddr=%h dhit=%b want 1,148,0", k, bus.dREN, bus.daddr, bus.dhit);
      end
    end
    @(negedge CLK);
    bus.dwait = 1'b0;
    #1;
    checks++; if (bus.dREN !== 1'b1 || bus.daddr !== 32'h148 || bus.dhit !== 1'b0) begin errors++; $display("FAIL stall_release dREN=%b daddr=%h dhit=%b", bus.dREN, bus.daddr, bus.dhit); end
    @(negedge CLK);
    #1;
    checks++; if (bus.dREN !== 1'b1 || bus.daddr !== 32'h14C) begin errors++; $display("FAIL stall_next daddr=%h want=14c", bus.daddr); end
    @(negedge CLK);
    #1;
    checks++; if (bus.dhit !== 1'b1 || bus.dmemload !== el) begin errors++; $display("FAIL stall_hit dhit=%b data=%h want 1,%h", bus.dhit, bus.dmemload, el); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_llsc();
    int er, ew; logic [31:0] el;
    model_op(0, 32'h80, 32'h0, er, ew, el);
    do_req(0, 1, 1, 32'h80, 32'h0);
    checks++; if (last_load !== el) begin errors++; $display("FAIL ll_data got=%h want=%h", last_load, el); end
`ifdef DCACHE_LLSC_EN
    model_op(1, 32'h80, 32'h11110000, er, ew, el);
    do_req(1, 0, 0, 32'h80, 32'h11110000);
    do_req(1, 0, 1, 32'h80, 32'h22220000);
    checks++; if (last_load !== 32'h0) begin errors++; $display("FAIL sc_broken_result got=%h want=0", last_load); end
    do_req(0, 1, 0, 32'h80, 32'h0);
    checks++; if (last_load !== 32'h11110000) begin errors++; $display("FAIL sc_broken_mem got=%h want=11110000", last_load); end
    do_req(0, 1, 1, 32'h80, 32'h0);
    model_op(1, 32'h80, 32'h33330000, er, ew, el);
    do_req(1, 0, 1, 32'h80, 32'h33330000);
    checks++; if (last_load !== 32'h1) begin errors++; $display("FAIL sc_ok_result got=%h want=1", last_load); end
    do_req(1, 0, 1, 32'h80, 32'h44440000);
    checks++; if (last_load !== 32'h0) begin errors++; $display("FAIL sc_reuse_result got=%h want=0", last_load); end
`else
    model_op(1, 32'h80, 32'h33330000, er, ew, el);
    do_req(1, 0, 1, 32'h80, 32'h33330000);
    checks++; if (last_load !== 32'h1) begin errors++; $display("FAIL sc_plain_result got=%h want=1", last_load); end
`endif
    do_req(0, 1, 0, 32'h80, 32'h0);
    checks++; if (last_load !== 32'h33330000) begin errors++; $display("FAIL sc_mem got=%h want=33330000", last_load); end
  endtask

  task automatic test_random();
    int er, ew; logic [31:0] el, addr, data; bit we, re;
    wait_pct = 25;
    for (int n = 0; n < 150; n++) begin
      addr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 3) |
             ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      data = $urandom();
      we   = ($urandom_range(0, 1) == 1);
      re   = !we || ($urandom_range(0, 3) == 0);
      model_op(we, addr, data, er, ew, el);
      do_req(we, re, 0, addr, data);
      checks++;
      if (n_rd !== er || n_wr !== ew) begin
        errors++; $display("FAIL rand_traffic op%0d addr=%h rd=%0d wr=%0d want %0d,%0d", n, addr, n_rd, n_wr, er, ew);
      end
      if (!we) begin
        checks++;
        if (last_load !== el) begin errors++; $display("FAIL rand_load op%0d addr=%h got=%h want=%h", n, addr, last_load, el); end
      end
    end
    wait_pct = 0;
  endtask

  task automatic test_reset_mid_wb();
    int er, ew, cyc; logic [31:0] el; bit found;
    pulse_reset();
    wait_pct = 0;
    model_op(1, 32'h40, 32'hCAFE0001, er, ew, el);
    do_req(1, 0, 0, 32'h40, 32'hCAFE0001);
    @(negedge CLK);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h240; bus.dwait = 1'b0;
    found = 0; cyc = 0;
    while (!found && cyc < 20) begin
      #1;
      if (bus.dWEN && bus.daddr == 32'h44) found = 1;
      else begin @(negedge CLK); cyc++; end
    end
    checks++; if (!found) begin errors++; $display("FAIL wb1_reached got=0 want=1"); end
    nRST = 1'b0;
    #1;
    checks++;
    if (bus.dhit !== 1'b0 || bus.dREN !== 1'b0 || bus.dWEN !== 1'b0 || bus.daddr !== 32'h0 ||
        bus.dstore !== 32'h0 || bus.dmemload !== 32'h0 || bus.flushed !== 1'b0) begin
      errors++; $display("FAIL midwb_reset_outputs dhit=%b dREN=%b dWEN=%b daddr=%h dstore=%h load=%h flushed=%b want all 0",
                         bus.dhit, bus.dREN, bus.dWEN, bus.daddr, bus.dstore, bus.dmemload, bus.flushed);
    end
    @(negedge CLK);
    nRST = 1'b1;
    idle_inputs();
    model_reset();
    model_op(0, 32'h240, 32'h0, er, ew, el);
    do_req(0, 1, 0, 32'h240, 32'h0);
    checks++; if (n_wr !== 0 || n_rd !== 2) begin errors++; $display("FAIL post_reset_traffic wr=%0d rd=%0d want 0,2", n_wr, n_rd); end
    checks++; if (last_load !== el) begin errors++; $display("FAIL post_reset_data got=%h want=%h", last_load, el); end
  endtask

  task automatic test_flush();
    int er, ew, cyc, hits, reads, bad; logic [31:0] el; bit seen, done;
    pulse_reset();
    wait_pct = 0;
    model_op(1, 32'h10, 32'h11112222, er, ew, el);  do_req(1, 0, 0, 32'h10, 32'h11112222);
    model_op(1, 32'h2C, 32'h33334444, er, ew, el);  do_req(1, 0, 0, 32'h2C, 32'h33334444);
    model_op(0, 32'h18, 32'h0, er, ew, el);         do_req(0, 1, 0, 32'h18, 32'h0);
    model_op(0, 32'h1F8, 32'h0, er, ew, el);
    @(negedge CLK);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h1F8; bus.dwait = 1'b0;
    seen = 0; cyc = 0;
    while (!seen && cyc < 50) begin
      #1;
      if (bus.dhit) begin seen = 1; last_load = bus.dmemload; end
      @(negedge CLK);
      cyc++;
      if (cyc == 1) bus.halt = 1'b1;
    end
    checks++; if (!seen || last_load !== el) begin errors++; $display("FAIL halt_deferred_hit seen=%b data=%h want 1,%h", seen, last_load, el); end
    bus.dmemaddr = 32'h10;
    n_wr = 0; hits = 0; reads = 0; cyc = 0; done = 0;
    tr_addr.delete();
    while (!done) begin
      bus.dwait = ($urandom_range(0, 99) < 30);
      #1;
      if (bus.dhit) hits++;
      if (bus.dREN) reads++;
      if (bus.dWEN && !bus.dwait) begin n_wr++; tr_addr.push_back(bus.daddr); end
      if (bus.flushed) done = 1;
      else if (cyc > 200) begin errors++; $display("FAIL flush_timeout flushed=0 after 200 cycles"); done = 1; end
      else begin @(negedge CLK); cyc++; end
    end
    checks++; if (n_wr !== 4) begin errors++; $display("FAIL flush_writes got=%0d want=4", n_wr); end
    checks++;
    if (tr_addr.size() != 4 || tr_addr[0] !== 32'h10 || tr_addr[1] !== 32'h14 ||
        tr_addr[2] !== 32'h28 || tr_addr[3] !== 32'h2C) begin
      errors++; $display("FAIL flush_addrs got=%p want 10,14,28,2c", tr_addr);
    end
    checks++; if (hits !== 0 || reads !== 0) begin errors++; $display("FAIL flush_ignores_req dhit=%0d dREN=%0d want 0,0", hits, reads); end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      bus.dwait = 1'b0;
      #1;
      checks++;
      if (bus.flushed !== 1'b1 || bus.dhit !== 1'b0) begin
        errors++; $display("FAIL done_hold%0d flushed=%b dhit=%b want 1,0", k, bus.flushed, bus.dhit);
      end
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (bmem[i] !== arch[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL flush_coherent stale_words=%0d want=0", bad); end
    @(negedge CLK);
    bus.halt = 1'b0;
    idle_inputs();
  endtask

  initial begin
    wait_pct = 0;
    test_reset();
    test_cold_load();
    test_dirty_miss();
    test_dwait_stall();
    test_llsc();
    test_random();
    test_reset_mid_wb();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
